// File: rtl/wb_arbiter_rr_2_if.sv
// One Wishbone link between a master and a slave port.
// dat_w flows master to slave, dat_r flows slave to master.
interface wb_arbiter_rr_2_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH-1:0]   dat_r;
   logic                    we;
   logic [SELECT_WIDTH-1:0] sel;
   logic                    stb;
   logic                    cyc;
   logic                    ack;
   logic                    err;

   modport master (
      output adr, dat_w, we, sel, stb, cyc,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, dat_w, we, sel, stb, cyc,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_arbiter_rr_2.sv
// Two-master round-robin Wishbone arbiter; a grant lasts for the owner's whole cyc.
// A watchdog answers err to the owner when the slave never terminates a strobe.
//
// state  | meaning
// G_NONE | bus idle, s_* outputs held at 0
// G_M0   | master 0 owns the slave until it drops cyc
// G_M1   | master 1 owns the slave until it drops cyc
module wb_arbiter_rr_2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_arbiter_rr_2_if.slave  m0,
   wb_arbiter_rr_2_if.slave  m1,
   wb_arbiter_rr_2_if.master s
);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      G_NONE = 2'd0,
      G_M0   = 2'd1,
      G_M1   = 2'd2
   } grant_t;

   grant_t                  grant;
   grant_t                  grant_nxt;
   logic                    last_m1;
   logic                    last_m1_nxt;
   logic [TW-1:0]           tcount;
   logic [TW-1:0]           tcount_nxt;
   logic                    timeout;

   logic [ADDR_WIDTH-1:0]   adr_mux;
   logic [DATA_WIDTH-1:0]   dat_mux;
   logic                    we_mux;
   logic [SELECT_WIDTH-1:0] sel_mux;
   logic                    stb_mux;
   logic                    cyc_mux;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant   <= G_NONE;
         last_m1 <= 1'b1;
         tcount  <= '0;
      end else begin
         grant   <= grant_nxt;
         last_m1 <= last_m1_nxt;
         tcount  <= tcount_nxt;
      end
   end

   always_comb begin
      grant_nxt   = grant;
      last_m1_nxt = last_m1;
      case (grant)
         G_NONE: begin
            if (m0.cyc && m1.cyc) begin
               grant_nxt = last_m1 ? G_M0 : G_M1;
            end else if (m0.cyc) begin
               grant_nxt = G_M0;
            end else if (m1.cyc) begin
               grant_nxt = G_M1;
            end
         end
         G_M0: begin
            if (!m0.cyc) begin
               grant_nxt = m1.cyc ? G_M1 : G_NONE;
            end
         end
         G_M1: begin
            if (!m1.cyc) begin
               grant_nxt = m0.cyc ? G_M0 : G_NONE;
            end
         end
         default: grant_nxt = G_NONE;
      endcase
      if ((grant_nxt != grant) && (grant_nxt != G_NONE)) begin
         last_m1_nxt = (grant_nxt == G_M1);
      end
   end

   always_comb begin
      adr_mux = '0;
      dat_mux = '0;
      we_mux  = 1'b0;
      sel_mux = '0;
      stb_mux = 1'b0;
      cyc_mux = 1'b0;
      case (grant)
         G_M0: begin
            adr_mux = m0.adr;
            dat_mux = m0.dat_w;
            we_mux  = m0.we;
            sel_mux = m0.sel;
            stb_mux = m0.stb;
            cyc_mux = m0.cyc;
         end
         G_M1: begin
            adr_mux = m1.adr;
            dat_mux = m1.dat_w;
            we_mux  = m1.we;
            sel_mux = m1.sel;
            stb_mux = m1.stb;
            cyc_mux = m1.cyc;
         end
         default: ;
      endcase
   end

   assign timeout = (TIMEOUT > 0) && (tcount == TW'(TIMEOUT));

   // The timeout cycle withdraws the strobe, so the counter clears on its own next edge.
   always_comb begin
      tcount_nxt = '0;
      if ((TIMEOUT > 0) && (grant_nxt == grant) &&
          s.cyc && s.stb && !s.ack && !s.err) begin
         tcount_nxt = tcount + TW'(1);
      end
   end

   assign s.adr   = adr_mux;
   assign s.dat_w = dat_mux;
   assign s.we    = we_mux;
   assign s.sel   = sel_mux;
   assign s.cyc   = cyc_mux;
   assign s.stb   = stb_mux & ~timeout;

   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;

   // A genuine slave ack wins over a coincident watchdog expiry.
   assign m0.ack = (grant == G_M0) & s.ack;
   assign m1.ack = (grant == G_M1) & s.ack;
   assign m0.err = (grant == G_M0) & (s.err | (timeout & ~s.ack));
   assign m1.err = (grant == G_M1) & (s.err | (timeout & ~s.ack));
endmodule
